// File: rtl/dr_alm_pkg.sv
// rtl/dr_alm_pkg.sv - shared defaults and helpers for the pipelined DR-ALM multiplier
package dr_alm_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_KEEP_MAX = 5;

  // Out-of-range truncation requests fall back to the widest kept field.
  function automatic int eff_keep(input int keep, input int keep_max);
    return (keep == 0 || keep > keep_max) ? keep_max : keep;
  endfunction

endpackage

// File: rtl/dr_alm_lod.sv
// rtl/dr_alm_lod.sv - binary-tree leading-one detector, log2 depth, non-power-of-two widths padded
module dr_alm_lod #(
  parameter int WIDTH = 16,
  parameter int LODW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  output logic [LODW-1:0]  k,
  output logic             found
);

  localparam int P = 1 << LODW;

  logic [P-1:0]    node_f;
  logic [LODW-1:0] node_k [P];

  // Each level merges sibling pairs in place; the upper child wins and contributes bit l.
  always_comb begin
    node_f = '0;
    node_f[WIDTH-1:0] = x;
    for (int i = 0; i < P; i++) node_k[i] = '0;
    for (int l = 0; l < LODW; l++) begin
      for (int j = 0; j < (P >> (l + 1)); j++) begin
        node_k[j] = node_f[2*j+1] ? (node_k[2*j+1] | LODW'(1 << l)) : node_k[2*j];
        node_f[j] = node_f[2*j] | node_f[2*j+1];
      end
    end
  end

  assign k     = node_k[0];
  assign found = node_f[0];

endmodule

// File: rtl/pipelined_dr_alm.sv
// rtl/pipelined_dr_alm.sv - 3-stage signed dynamic-range approximate log multiplier with valid/ready
module pipelined_dr_alm
  import dr_alm_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  KEEP_MAX = DEF_KEEP_MAX,
  localparam int KW       = $clog2(KEEP_MAX + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [KW-1:0]      i_keep,
  input  logic               i_comp,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_z
);

  localparam int LODW = $clog2(WIDTH);
  localparam int KSW  = LODW + 1;
  localparam int ZW   = 2 * WIDTH;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [LODW-1:0]  ka;
    logic [LODW-1:0]  kb;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [KW-1:0]    keep;
    logic             comp;
  } s1_t;

  // The carry out of the fraction sum is folded into k, so only the fraction is kept.
  typedef struct packed {
    logic                sign;
    logic                zero;
    logic [KSW-1:0]      k;
    logic [KEEP_MAX-1:0] frac;
  } s2_t;

  logic          en1, en2, en3;
  logic          v1, v2, v3;
  s1_t           s1_d, s1_q;
  s2_t           s2_d, s2_q;
  logic [ZW-1:0] z_d, z_q;

  assign en3     = !v3 || i_ready;
  assign en2     = !v2 || en3;
  assign en1     = !v1 || en2;
  assign o_ready = en1;
  assign o_valid = v3;
  assign o_z     = z_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [LODW-1:0]  ka, kb;
  logic             found_a, found_b;

  // Two's-complement negate of the most negative value yields 2^(W-1) as unsigned, exactly.
  assign abs_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign abs_b = i_b[WIDTH-1] ? -i_b : i_b;

  dr_alm_lod #(.WIDTH(WIDTH), .LODW(LODW)) u_lod_a (
    .x     (abs_a),
    .k     (ka),
    .found (found_a)
  );

  dr_alm_lod #(.WIDTH(WIDTH), .LODW(LODW)) u_lod_b (
    .x     (abs_b),
    .k     (kb),
    .found (found_b)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.sign  = i_a[WIDTH-1] ^ i_b[WIDTH-1];
    s1_d.zero  = !(found_a && found_b);
    s1_d.ka    = ka;
    s1_d.kb    = kb;
    s1_d.abs_a = abs_a;
    s1_d.abs_b = abs_b;
    s1_d.keep  = KW'(eff_keep(int'(i_keep), KEEP_MAX));
    s1_d.comp  = i_comp;
  end

  logic [LODW-1:0]     sh_a, sh_b;
  logic [KW-1:0]       drop;
  logic [KEEP_MAX-1:0] ta, tb;
  logic [KEEP_MAX:0]   cbit, sum;

  // Normalise so the leading one sits at bit W-1; the next KEEP_MAX bits are the fraction.
  always_comb begin
    sh_a = LODW'(WIDTH - 1) - s1_q.ka;
    sh_b = LODW'(WIDTH - 1) - s1_q.kb;
    drop = KW'(KEEP_MAX) - s1_q.keep;
    ta   = KEEP_MAX'((s1_q.abs_a << sh_a) >> (WIDTH - 1 - KEEP_MAX));
    tb   = KEEP_MAX'((s1_q.abs_b << sh_b) >> (WIDTH - 1 - KEEP_MAX));
    ta   = (ta >> drop) << drop;
    tb   = (tb >> drop) << drop;
    cbit = s1_q.comp ? ({{KEEP_MAX{1'b0}}, 1'b1} << drop) : '0;
    sum  = {1'b0, ta} + {1'b0, tb} + cbit;

    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero;
    s2_d.k    = KSW'(s1_q.ka) + KSW'(s1_q.kb) + KSW'(sum[KEEP_MAX]);
    s2_d.frac = sum[KEEP_MAX-1:0];
  end

  logic [KEEP_MAX:0] mant;
  logic [ZW-1:0]     mag;

  always_comb begin
    mant = {1'b1, s2_q.frac};
    if (s2_q.k >= KSW'(KEEP_MAX)) begin
      mag = ZW'(mant) << (s2_q.k - KSW'(KEEP_MAX));
    end else begin
      mag = ZW'(mant) >> (KSW'(KEEP_MAX) - s2_q.k);
    end
    z_d = s2_q.zero ? '0 : (s2_q.sign ? -mag : mag);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      z_q  <= '0;
    end else begin
      if (en1) begin
        v1 <= i_valid;
        if (i_valid) s1_q <= s1_d;
      end
      if (en2) begin
        v2 <= v1;
        if (v1) s2_q <= s2_d;
      end
      if (en3) begin
        v3 <= v2;
        if (v2) z_q <= z_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_dr_alm.sv
// tb/tb_pipelined_dr_alm.sv - directed vectors, flow-control stream, reset and width sweep for pipelined_dr_alm
module tb_pipelined_dr_alm;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, ordy, ov, ir, comp;
  logic [15:0] a, b;
  logic [2:0]  keep;
  logic [31:0] z;

  logic        iv8, ordy8, ov8, ir8, comp8;
  logic [7:0]  a8, b8;
  logic [2:0]  keep8;
  logic [15:0] z8;

  logic        iv24, ordy24, ov24, ir24, comp24;
  logic [23:0] a24, b24;
  logic [2:0]  keep24;
  logic [47:0] z24;

  always #5 clk = ~clk;

  pipelined_dr_alm #(.WIDTH(16), .KEEP_MAX(5)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy), .i_a(a), .i_b(b),
    .i_keep(keep), .i_comp(comp), .o_valid(ov), .i_ready(ir), .o_z(z)
  );

  pipelined_dr_alm #(.WIDTH(8), .KEEP_MAX(5)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv8), .o_ready(ordy8), .i_a(a8), .i_b(b8),
    .i_keep(keep8), .i_comp(comp8), .o_valid(ov8), .i_ready(ir8), .o_z(z8)
  );

  pipelined_dr_alm #(.WIDTH(24), .KEEP_MAX(5)) dut24 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv24), .o_ready(ordy24), .i_a(a24), .i_b(b24),
    .i_keep(keep24), .i_comp(comp24), .o_valid(ov24), .i_ready(ir24), .o_z(z24)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: fraction below the leading one scaled to km bits, truncated, summed, antilogged.
  function automatic longint ref_mul(input int w, input int km, input longint ra, input longint rb,
                                     input int rkeep, input int rcomp);
    longint ua, ub, fa, fb, sum, m, p;
    int     ka, kb, kk, s, kt;
    if (ra == 0 || rb == 0) return 0;
    ua = (ra < 0) ? -ra : ra;
    ub = (rb < 0) ? -rb : rb;
    ka = 0;
    kb = 0;
    for (int i = 0; i < w; i++) begin
      if (ua[i]) ka = i;
      if (ub[i]) kb = i;
    end
    kk  = (rkeep == 0 || rkeep > km) ? km : rkeep;
    s   = km - kk;
    fa  = ((ua - (longint'(1) << ka)) << km) >> ka;
    fb  = ((ub - (longint'(1) << kb)) << km) >> kb;
    fa  = (fa >> s) << s;
    fb  = (fb >> s) << s;
    sum = fa + fb + (rcomp != 0 ? (longint'(1) << s) : longint'(0));
    kt  = ka + kb + int'(sum >> km);
    m   = (longint'(1) << km) + (sum & ((longint'(1) << km) - 1));
    p   = (kt >= km) ? (m << (kt - km)) : (m >> (km - kt));
    return ((ra < 0) != (rb < 0)) ? -p : p;
  endfunction

  // Presents one beat at the current negedge and counts clocks until o_valid.
  task automatic run_beat(input logic [15:0] ta, input logic [15:0] tb, input logic [2:0] tk,
                          input logic tc, output longint res, output int lat);
    a = ta; b = tb; keep = tk; comp = tc; iv = 1'b1; ir = 1'b1;
    #1;
    chk("beat accepted", longint'(ordy), 1);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      iv = 1'b0;
    end while (!ov && lat < 10);
    res = longint'($signed(z));
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  keep;
    logic        comp;
    longint      exp;
  } vec_t;

  vec_t        vecs[12];
  logic [15:0] sa[20], sb[20];
  logic [2:0]  sk[20];
  logic        sc[20];
  longint      q8[$], q24[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint res;
    int     lat;
    int     sent, got, infl;
    logic   fin, fout;

    vecs[0]  = '{16'hFFFC, 16'd5,     3'd5, 1'b0, -20};
    vecs[1]  = '{16'd3,    16'd3,     3'd5, 1'b1, 8};
    vecs[2]  = '{16'd7,    16'd7,     3'd1, 1'b0, 32};
    vecs[3]  = '{16'h8000, 16'h8000,  3'd5, 1'b0, 1073741824};
    vecs[4]  = '{16'h8000, 16'h8000,  3'd5, 1'b1, 1107296256};
    vecs[5]  = '{16'd0,    16'hFB2E,  3'd3, 1'b1, 0};
    vecs[6]  = '{16'd12345, 16'd0,    3'd5, 1'b1, 0};
    vecs[7]  = '{16'd3,    16'd3,     3'd0, 1'b1, 8};
    vecs[8]  = '{16'd7,    16'd7,     3'd7, 1'b0, 48};
    vecs[9]  = '{16'hFFFF, 16'd1,     3'd5, 1'b0, -1};
    vecs[10] = '{16'h7FFF, 16'h7FFF,  3'd5, 1'b0, 1040187392};
    vecs[11] = '{16'd100,  16'hFFFD,  3'd2, 1'b1, -320};

    rst = 1'b1; iv = 1'b0; ir = 1'b1; a = '0; b = '0; keep = '0; comp = 1'b0;
    iv8 = 1'b0; ir8 = 1'b1; a8 = '0; b8 = '0; keep8 = '0; comp8 = 1'b0;
    iv24 = 1'b0; ir24 = 1'b1; a24 = '0; b24 = '0; keep24 = '0; comp24 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset o_valid", longint'(ov), 0);
    chk("reset o_z", longint'(z), 0);
    chk("reset o_ready", longint'(ordy), 1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_beat(vecs[i].a, vecs[i].b, vecs[i].keep, vecs[i].comp, res, lat);
      chk($sformatf("vec%0d o_z", i), res, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), longint'(lat), 3);
    end
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
      sk[i] = 3'($urandom_range(0, 7));
      sc[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; infl = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(negedge clk);
      ir = 1'($urandom_range(0, 1));
      iv = (sent < 20);
      if (sent < 20) begin
        a = sa[sent]; b = sb[sent]; keep = sk[sent]; comp = sc[sent];
      end
      #1;
      chk("stream o_ready", longint'(ordy), longint'((infl < 3) || ir));
      if (infl == 0) chk("stream idle o_valid", longint'(ov), 0);
      fin  = iv && ordy;
      fout = ov && ir;
      if (fout) begin
        chk($sformatf("stream beat%0d", got), longint'($signed(z)),
            ref_mul(16, 5, longint'($signed(sa[got])), longint'($signed(sb[got])),
                    int'(sk[got]), int'(sc[got])));
        got++;
      end
      if (fin) sent++;
      infl = infl + int'(fin) - int'(fout);
    end
    chk("stream delivered", longint'(got), 20);
    @(negedge clk);
    iv = 1'b0;

    ir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'd3; b = 16'd3; keep = 3'd5; comp = 1'b0; iv = 1'b1;
    end
    @(negedge clk);
    iv = 1'b0;
    #1;
    chk("full o_ready", longint'(ordy), 0);
    chk("full o_valid", longint'(ov), 1);
    rst = 1'b1;
    #1;
    chk("midreset o_valid", longint'(ov), 0);
    chk("midreset o_z", longint'(z), 0);
    chk("midreset o_ready", longint'(ordy), 1);
    @(negedge clk);
    rst = 1'b0;
    ir = 1'b1;
    @(negedge clk);
    run_beat(16'hFFFC, 16'd5, 3'd5, 1'b0, res, lat);
    chk("postreset o_z", res, -20);
    chk("postreset latency", longint'(lat), 3);

    for (int cyc = 0; cyc < 72; cyc++) begin
      @(negedge clk);
      if (ov8) begin
        if (q8.size() == 0) chk("w8 spurious beat", 1, 0);
        else chk("w8 sweep", longint'($signed(z8)), q8.pop_front());
      end
      if (ov24) begin
        if (q24.size() == 0) chk("w24 spurious beat", 1, 0);
        else chk("w24 sweep", longint'($signed(z24)), q24.pop_front());
      end
      if (cyc < 64) begin
        chk("sweep o_ready", longint'(ordy8 && ordy24), 1);
        a8     = (cyc % 8 == 0) ? 8'h80 : ((cyc % 16 == 5) ? 8'h00 : 8'($urandom));
        b8     = (cyc % 24 == 0) ? 8'h80 : 8'($urandom);
        a24    = (cyc % 8 == 0) ? 24'h800000 : 24'($urandom);
        b24    = (cyc % 16 == 3) ? 24'h000000 : ((cyc % 24 == 0) ? 24'h800000 : 24'($urandom));
        keep8  = 3'(cyc % 8);
        comp8  = 1'((cyc / 8) % 2);
        keep24 = 3'((cyc + 3) % 8);
        comp24 = 1'((cyc / 8) % 2);
        iv8    = 1'b1;
        iv24   = 1'b1;
        q8.push_back(ref_mul(8, 5, longint'($signed(a8)), longint'($signed(b8)),
                             int'(keep8), int'(comp8)));
        q24.push_back(ref_mul(24, 5, longint'($signed(a24)), longint'($signed(b24)),
                              int'(keep24), int'(comp24)));
      end else begin
        iv8  = 1'b0;
        iv24 = 1'b0;
      end
    end
    chk("w8 drained", longint'(q8.size()), 0);
    chk("w24 drained", longint'(q24.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
